// File: rtl/rom_fetch_unit.sv
// Sequential program-ROM reader: drives the ROM address, absorbs the one-cycle
// read latency and buffers {byte, pc} pairs in a prefetch FIFO for decode.
module rom_fetch_unit #(
  parameter int                   AddrWidth   = 8,
  parameter int                   FifoDepth   = 4,
  parameter logic [AddrWidth-1:0] ResetVector = 8'h00
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic [AddrWidth-1:0] ROM_ADDRESS,
  input  logic [7:0]           ROM_DATA,
  input  logic                 REDIRECT,
  input  logic [AddrWidth-1:0] REDIRECT_ADDR,
  output logic [7:0]           BYTE_OUT,
  output logic [AddrWidth-1:0] BYTE_PC,
  output logic                 BYTE_VALID,
  input  logic                 BYTE_READY
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW:0] DepthV = (CntW + 1)'(FifoDepth);

  logic [AddrWidth-1:0] pc_r;
  logic                 infl_r;
  logic [AddrWidth-1:0] infl_pc_r;
  logic [7:0]           mem_byte_r [FifoDepth];
  logic [AddrWidth-1:0] mem_pc_r   [FifoDepth];
  logic [PtrW-1:0]      rd_ptr_r;
  logic [PtrW-1:0]      wr_ptr_r;
  logic [CntW-1:0]      count_r;

  logic                 issue_s;
  logic                 push_s;
  logic                 pop_s;
  logic [CntW-1:0]      count_nxt_s;

  // Issue decision looks only at registered occupancy; a same-cycle pop is not credited.
  always_comb begin
    issue_s     = 1'b0;
    push_s      = infl_r;
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    if (({1'b0, count_r} + {{CntW{1'b0}}, infl_r}) < DepthV) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if ((count_r != {CntW{1'b0}}) && BYTE_READY) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CntW'(1'b1);
      2'b01:   count_nxt_s = count_r - CntW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Fetch PC, in-flight tracking and FIFO state; redirect overrides everything else.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_r      <= ResetVector;
      infl_r    <= 1'b0;
      infl_pc_r <= {AddrWidth{1'b0}};
      rd_ptr_r  <= {PtrW{1'b0}};
      wr_ptr_r  <= {PtrW{1'b0}};
      count_r   <= {CntW{1'b0}};
      for (int i = 0; i < FifoDepth; i++) begin
        mem_byte_r[i] <= 8'h00;
        mem_pc_r[i]   <= {AddrWidth{1'b0}};
      end
    end else if (REDIRECT) begin
      pc_r     <= REDIRECT_ADDR;
      infl_r   <= 1'b0;
      rd_ptr_r <= {PtrW{1'b0}};
      wr_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (issue_s) begin
        infl_r    <= 1'b1;
        infl_pc_r <= pc_r;
        pc_r      <= pc_r + {{(AddrWidth-1){1'b0}}, 1'b1};
      end else begin
        infl_r    <= 1'b0;
      end
      if (push_s) begin
        mem_byte_r[wr_ptr_r] <= ROM_DATA;
        mem_pc_r[wr_ptr_r]   <= infl_pc_r;
        wr_ptr_r             <= wr_ptr_r + PtrW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1'b1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Head of FIFO is shown straight from storage; only BYTE_VALID qualifies it.
  always_comb begin
    ROM_ADDRESS = pc_r;
    BYTE_OUT    = mem_byte_r[rd_ptr_r];
    BYTE_PC     = mem_pc_r[rd_ptr_r];
    BYTE_VALID  = (count_r != {CntW{1'b0}});
  end

endmodule
